// File: rtl/seq_fifo_ctrl.sv
// seq_fifo_ctrl: sequence buffer with replay (rewind), commit-based release,
// optional rising-edge request qualification, occupancy and sticky error flags.
module seq_fifo_ctrl #(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 2,
    parameter int EDGE_MODE = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              rewind,
    input  logic              commit,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   w_ptr,
    output logic [ADDR_W:0]   r_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W:0] ptr_one = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   b_ptr;
    logic              wr_q, rd_q;
    logic              eff_wr, eff_rd, blocked;
    logic              wr_ok, rd_ok, wr_rej, rd_rej;

    assign full  = (w_ptr[ADDR_W] != b_ptr[ADDR_W]) && (w_ptr[ADDR_W-1:0] == b_ptr[ADDR_W-1:0]);
    assign empty = w_ptr == r_ptr;
    assign count = w_ptr - b_ptr;

    always_comb begin
        eff_wr  = (EDGE_MODE != 0) ? wr_req & ~wr_q : wr_req;
        eff_rd  = (EDGE_MODE != 0) ? rd_req & ~rd_q : rd_req;
        blocked = clear | rewind | commit;
        wr_ok   = eff_wr & ~full & ~blocked;
        wr_rej  = eff_wr & full & ~blocked;
        rd_ok   = eff_rd & ~empty & ~blocked;
        rd_rej  = eff_rd & empty & ~blocked;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok)
            mem[w_ptr[ADDR_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            b_ptr     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            wr_q     <= wr_req;
            rd_q     <= rd_req;
            rd_valid <= rd_ok;
            if (rd_ok)
                rd_data <= mem[r_ptr[ADDR_W-1:0]];
            if (clear) begin
                w_ptr     <= '0;
                r_ptr     <= '0;
                b_ptr     <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else if (rewind) begin
                r_ptr <= b_ptr;
            end else if (commit) begin
                b_ptr <= r_ptr;
            end else begin
                if (wr_ok)
                    w_ptr <= w_ptr + ptr_one;
                if (rd_ok)
                    r_ptr <= r_ptr + ptr_one;
                overflow  <= overflow | wr_rej;
                underflow <= underflow | rd_rej;
            end
        end
    end
endmodule

// File: tb/tb_seq_fifo_ctrl.sv
// tb_seq_fifo_ctrl: directed bench with a read-data scoreboard; instance a is
// level-triggered, instance b is edge-qualified.
module tb_seq_fifo_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0, wr_req = 1'b0, rd_req = 1'b0, rewind = 1'b0, commit = 1'b0;
    logic [1:0] wr_data = '0;
    logic [1:0] a_rd_data, b_rd_data;
    logic       a_rd_valid, b_rd_valid;
    logic [4:0] a_w_ptr, a_r_ptr, a_count, b_w_ptr, b_r_ptr, b_count;
    logic       a_full, a_empty, a_overflow, a_underflow;
    logic       b_full, b_empty, b_overflow, b_underflow;

    int         vectors = 0;
    int         errs = 0;
    bit         sb_on = 1'b1;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    seq_fifo_ctrl #(.DEPTH(16), .DATA_W(2), .EDGE_MODE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .wr_req(wr_req), .wr_data(wr_data),
        .rd_req(rd_req), .rewind(rewind), .commit(commit), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .w_ptr(a_w_ptr), .r_ptr(a_r_ptr), .count(a_count),
        .full(a_full), .empty(a_empty), .overflow(a_overflow), .underflow(a_underflow)
    );

    seq_fifo_ctrl #(.DEPTH(16), .DATA_W(2), .EDGE_MODE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .wr_req(wr_req), .wr_data(wr_data),
        .rd_req(rd_req), .rewind(rewind), .commit(commit), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .w_ptr(b_w_ptr), .r_ptr(b_r_ptr), .count(b_count),
        .full(b_full), .empty(b_empty), .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (sb_on && a_rd_valid) begin
            if (sb.size() == 0)
                chk("spurious_rd_valid", {31'b0, a_rd_valid}, 32'd0);
            else
                chk("rd_data", {30'b0, a_rd_data}, {30'b0, sb.pop_front()});
        end
    endtask

    task automatic wr(input logic [1:0] d);
        wr_req = 1'b1; wr_data = d; step(); wr_req = 1'b0;
    endtask

    task automatic rd(input logic [1:0] exp);
        rd_req = 1'b1; sb.push_back(exp); step(); rd_req = 1'b0;
    endtask

    initial begin
        // 1: reset state, simple FIFO order
        step();
        reset_n = 1'b1;
        chk("rst_w_ptr", a_w_ptr, 0);
        chk("rst_r_ptr", a_r_ptr, 0);
        chk("rst_count", a_count, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_ovf", a_overflow, 0);
        chk("rst_udf", a_underflow, 0);
        for (int i = 0; i < 4; i++) wr(2'(i));
        chk("t1_count", a_count, 4);
        for (int i = 0; i < 4; i++) rd(2'(i));
        chk("t1_empty", a_empty, 1);
        chk("t1_count_after", a_count, 4);
        chk("t1_sb_drained", sb.size(), 0);

        // 2: fill, overflow, clear
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 16; i++) wr(2'(i));
        chk("t2_full", a_full, 1);
        chk("t2_count", a_count, 16);
        chk("t2_ovf_pre", a_overflow, 0);
        wr(2'd1);
        chk("t2_ovf", a_overflow, 1);
        chk("t2_w_ptr", a_w_ptr, 16);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t2_clr_w", a_w_ptr, 0);
        chk("t2_clr_count", a_count, 0);
        chk("t2_clr_full", a_full, 0);
        chk("t2_clr_ovf", a_overflow, 0);

        // 3: replay via rewind
        wr(2'd3); wr(2'd1); wr(2'd2);
        rd(2'd3); rd(2'd1); rd(2'd2);
        rewind = 1'b1; step(); rewind = 1'b0;
        chk("t3_r_ptr", a_r_ptr, 0);
        rd(2'd3); rd(2'd1); rd(2'd2);
        chk("t3_count", a_count, 3);
        chk("t3_sb_drained", sb.size(), 0);

        // 4: commit after each read, pointers wrap
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wr(2'((i * 3) % 4));
            chk("t4_count_w", a_count, 1);
            rd(2'((i * 3) % 4));
            commit = 1'b1; step(); commit = 1'b0;
            chk("t4_count_c", a_count, 0);
        end
        chk("t4_w_wrap", a_w_ptr, 8);
        chk("t4_r_wrap", a_r_ptr, 8);

        // 5: edge qualification and underflow on instance b
        sb_on = 1'b0;
        reset_n = 1'b0; step(); reset_n = 1'b1;
        wr_req = 1'b1; wr_data = 2'd2;
        for (int i = 0; i < 10; i++) step();
        wr_req = 1'b0;
        chk("t5_b_count", b_count, 1);
        chk("t5_b_w_ptr", b_w_ptr, 1);
        rd_req = 1'b1; step();
        chk("t5_b_rd_valid", b_rd_valid, 1);
        chk("t5_b_rd_data", b_rd_data, 2);
        step();
        chk("t5_b_rd_single", b_rd_valid, 0);
        rd_req = 1'b0; step();
        rd_req = 1'b1; step(); rd_req = 1'b0;
        chk("t5_b_udf", b_underflow, 1);
        chk("t5_b_rd_valid0", b_rd_valid, 0);
        chk("t5_b_r_ptr", b_r_ptr, 1);

        // 6: simultaneous read/write, then mid-stream reset
        reset_n = 1'b0; step(); reset_n = 1'b1;
        sb.delete(); sb_on = 1'b1;
        wr(2'd2); wr(2'd3);
        rd(2'd2);
        chk("t6_r_ptr", a_r_ptr, 1);
        chk("t6_count", a_count, 2);
        wr_req = 1'b1; wr_data = 2'd1; rd(2'd3); wr_req = 1'b0;
        chk("t6_w_ptr", a_w_ptr, 3);
        chk("t6_r_ptr2", a_r_ptr, 2);
        chk("t6_count2", a_count, 3);
        wr_req = 1'b1; rd_req = 1'b1; reset_n = 1'b0;
        step();
        wr_req = 1'b0; rd_req = 1'b0; reset_n = 1'b1;
        chk("t6_rst_w", a_w_ptr, 0);
        chk("t6_rst_r", a_r_ptr, 0);
        chk("t6_rst_count", a_count, 0);
        chk("t6_rst_empty", a_empty, 1);
        chk("t6_rst_full", a_full, 0);
        chk("t6_rst_valid", a_rd_valid, 0);
        chk("t6_rst_data", a_rd_data, 0);
        chk("t6_rst_b_data", b_rd_data, 0);
        chk("t6_rst_b_udf", b_underflow, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
